// File: rtl/muldiv_unit_if.sv
// Handshake and result bus between the pipeline control and the HI/LO
// multiply/divide unit.
//
// Handshake: the master raises start with op/opA/opB; the request is taken
// at the rising edge where start=1 and busy=0, and opA/opB/op are don't-care
// afterwards. busy stays high until the result is written; done pulses for
// one cycle in the first cycle the new hi/lo are visible. start while busy
// is dropped, never queued. mthi/mtlo are single-cycle writes honoured only
// while busy=0.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    modport master (
        output start, op, opA, opB, mthi, mtlo, wdata,
        input  busy, done, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, opA, opB, mthi, mtlo, wdata,
        output busy, done, hi, lo, dbg_state
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Signed operations run on operand magnitudes and fix signs in FINISH.
// acc/shreg are shared: multiply keeps {upper partial, multiplier/lower
// product}, divide keeps {partial remainder, dividend/quotient}.
module muldiv_unit (
    input  logic          clock,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic [1:0]  op_q;
    logic [31:0] acc;
    logic [31:0] shreg;
    logic [31:0] b_mag;
    logic [31:0] a_orig;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        is_div;
    logic        is_signed;
    logic        in_signed;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign in_signed = ~bus.op[0];

    // Operand magnitudes taken at accept time; unsigned ops pass through.
    assign a_mag_in = (in_signed && bus.opA[31]) ? (32'd0 - bus.opA) : bus.opA;
    assign b_mag_in = (in_signed && bus.opB[31]) ? (32'd0 - bus.opB) : bus.opB;

    // One shift-add step; the 33rd bit is the carry shifted into the product.
    assign mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, b_mag} : 33'd0);

    // One restoring-division step: bring in the next dividend bit and trial-subtract.
    assign div_shift = {acc, shreg[31]};
    assign div_trial = div_shift - {1'b0, b_mag};

    // Sign fix-up of the magnitude results.
    assign prod     = {acc, shreg};
    assign prod_fix = (is_signed && neg_q) ? (64'd0 - prod) : prod;
    assign quo_fix  = (is_signed && neg_q) ? (32'd0 - shreg) : shreg;
    assign rem_fix  = (is_signed && neg_r) ? (32'd0 - acc) : acc;

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.dbg_state = state;

    // Control FSM plus iteration datapath and HI/LO registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= 5'd0;
            op_q   <= 2'd0;
            acc    <= 32'd0;
            shreg  <= 32'd0;
            b_mag  <= 32'd0;
            a_orig <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.mthi) hi_q <= bus.wdata;
                    if (bus.mtlo) lo_q <= bus.wdata;
                    if (bus.start) begin
                        op_q   <= bus.op;
                        acc    <= 32'd0;
                        shreg  <= a_mag_in;
                        b_mag  <= b_mag_in;
                        a_orig <= bus.opA;
                        neg_q  <= bus.opA[31] ^ bus.opB[31];
                        neg_r  <= bus.opA[31];
                        count  <= 5'd0;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        if (!div_trial[32]) begin
                            acc   <= div_trial[31:0];
                            shreg <= {shreg[30:0], 1'b1};
                        end else begin
                            acc   <= {acc[30:0], shreg[31]};
                            shreg <= {shreg[30:0], 1'b0};
                        end
                    end else begin
                        acc   <= mul_sum[32:1];
                        shreg <= {mul_sum[0], shreg[31:1]};
                    end
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= S_FINISH;
                end
                S_FINISH: begin
                    if (is_div) begin
                        if (b_mag == 32'd0) begin
                            // Divide by zero: defined result, original dividend in HI.
                            hi_q <= a_orig;
                            lo_q <= 32'hFFFF_FFFF;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, control corner cases
// and randomized operations against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 64;

    logic clock;
    logic reset;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: {hi, lo} from the architectural definition of each op.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] res;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Driver: one operation. mode 0 normal, 1 start+mthi injected at cycle 5,
    // 2 reset asserted at cycle 10 (no result expected).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mode, input bit no_wait);
        int lat;
        logic [63:0] e;
        if (!no_wait) @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        if (mode != 2) exp_q.push_back(model(op, a, b));
        @(negedge clock);
        bus.start = 1'b0;
        bus.opA   = $urandom;
        bus.opB   = $urandom;
        bus.op    = 2'($urandom_range(0, 3));
        check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
        lat = 0;
        while (!bus.done && lat < 40) begin
            if (mode == 1 && lat == 5) begin
                bus.start = 1'b1;
                bus.mthi  = 1'b1;
                bus.wdata = 32'h1234;
                bus.opA   = 32'h7;
                bus.opB   = 32'h3;
            end
            if (mode == 2 && lat == 10) reset = 1'b1;
            @(negedge clock);
            lat++;
            bus.start = 1'b0;
            bus.mthi  = 1'b0;
            if (mode == 2 && lat == 11) begin
                check("rst_mid_hi", {32'd0, bus.hi}, 64'd0);
                check("rst_mid_lo", {32'd0, bus.lo}, 64'd0);
                check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
                check("rst_mid_done", {63'd0, bus.done}, 64'd0);
                m_hi = 32'd0;
                m_lo = 32'd0;
                reset = 1'b0;
                return;
            end
        end
        check("latency", 64'(lat), 64'd33);
        check("busy_at_done", {63'd0, bus.busy}, 64'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
            check("lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
        @(negedge clock);
        check("done_width", {63'd0, bus.done}, 64'd0);
        check("hold_hi", {32'd0, bus.hi}, {32'd0, m_hi});
        check("hold_lo", {32'd0, bus.lo}, {32'd0, m_lo});
    endtask

    // Driver: MTHI/MTLO write in IDLE.
    task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
        @(negedge clock);
        bus.mthi  = wh;
        bus.mtlo  = wl;
        bus.wdata = d;
        @(negedge clock);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
        check("mt_hi", {32'd0, bus.hi}, {32'd0, m_hi});
        check("mt_lo", {32'd0, bus.lo}, {32'd0, m_lo});
        check("mt_done", {63'd0, bus.done}, 64'd0);
        check("mt_busy", {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.opA   = 32'd0;
        bus.opB   = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_hi", {32'd0, bus.hi}, 64'd0);
        check("reset_lo", {32'd0, bus.lo}, 64'd0);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        reset = 1'b0;

        // Directed cases
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(2'b11, 32'd100, 32'd0, 0, 0);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0, 0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);

        // MTHI/MTLO in IDLE
        mt_write(1'b0, 1'b1, 32'h0000_CAFE);
        mt_write(1'b1, 1'b0, 32'hDEAD_0001);
        mt_write(1'b1, 1'b1, 32'h5A5A_A5A5);

        // Ignored start/mthi while busy, then reset mid-operation
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0);
        run_op(2'b00, 32'h0000_0123, 32'hFFFF_0001, 2, 0);
        run_op(2'b11, 32'd1000, 32'd7, 0, 1);

        // Randomized operations with occasional writes and corner operands
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            run_op(2'($urandom_range(0, 3)), a, b, 0, 0);
        end

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
